// File: rtl/fpu_pkg.sv
// Shared FPU unit indices, fflags bit positions and the op-to-unit decode.
// Results retire in issue order; unit indices match the dispatcher's unit_sel encoding.
package fpu_pkg;

  localparam int NUM_FPU_UNITS = 7;
  localparam int FPU_UW        = 3;

  localparam logic [FPU_UW-1:0] FPU_UNIT_ARITH   = 3'd0;
  localparam logic [FPU_UW-1:0] FPU_UNIT_SGN_MOD = 3'd1;
  localparam logic [FPU_UW-1:0] FPU_UNIT_FTOI    = 3'd2;
  localparam logic [FPU_UW-1:0] FPU_UNIT_ITOF    = 3'd3;
  localparam logic [FPU_UW-1:0] FPU_UNIT_CMP     = 3'd4;
  localparam logic [FPU_UW-1:0] FPU_UNIT_SEL     = 3'd5;
  localparam logic [FPU_UW-1:0] FPU_UNIT_CLASS   = 3'd6;

  // fflags layout is {IV,DZ,OF,UF,IE}
  localparam int FFLAG_W  = 5;
  localparam int FFLAG_IV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_IE = 0;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SQRT, OP_FMADD,
    OP_SGNJ, OP_SGNJN, OP_SGNJX,
    OP_FCVT_W_S, OP_FCVT_S_W,
    OP_FEQ, OP_FLT, OP_FLE,
    OP_FMIN, OP_FMAX,
    OP_FCLASS
  } fpu_op_t;

  function automatic logic [FPU_UW-1:0] fpu_op_unit(input fpu_op_t op);
    case (op)
      OP_SGNJ, OP_SGNJN, OP_SGNJX: return FPU_UNIT_SGN_MOD;
      OP_FCVT_W_S:                 return FPU_UNIT_FTOI;
      OP_FCVT_S_W:                 return FPU_UNIT_ITOF;
      OP_FEQ, OP_FLT, OP_FLE:      return FPU_UNIT_CMP;
      OP_FMIN, OP_FMAX:            return FPU_UNIT_SEL;
      OP_FCLASS:                   return FPU_UNIT_CLASS;
      default:                     return FPU_UNIT_ARITH;
    endcase
  endfunction

endpackage

// File: rtl/fpu_order_fifo.sv
// Issue-order FIFO of unit indices; push/pop take effect at the next edge, head is combinational.
// Caller must not push when full; flush clears everything and overrides push/pop.
module fpu_order_fifo #(
  parameter int DEPTH = 4,
  parameter int UW    = 3,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [UW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [UW-1:0] head
);

  logic [UW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: entries are only read while count covers them.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fpu_dispatcher.sv
// Issues ops to NUM_UNITS FPU units and retires their results in issue order via an order FIFO.
// Issue stalls when the FIFO is full (no same-cycle pop bypass); non-head results are held off.
module fpu_dispatcher
  import fpu_pkg::*;
#(
  parameter int NUM_UNITS = 7,
  parameter int DEPTH     = 4,
  parameter int W         = 32,
  localparam int UW       = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       valid_in,
  output logic                       ready_out,
  input  logic [UW-1:0]              unit_sel,
  output logic [NUM_UNITS-1:0]       unit_valid,
  input  logic [NUM_UNITS-1:0]       unit_ready,
  input  logic [NUM_UNITS-1:0]       res_valid,
  output logic [NUM_UNITS-1:0]       res_ready,
  input  logic [NUM_UNITS*W-1:0]     res_data,
  input  logic [NUM_UNITS*FFLAG_W-1:0] res_flags,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic [W-1:0]               y,
  output logic [FFLAG_W-1:0]         fflags,
  output logic                       busy
);

  localparam int CW = $clog2(DEPTH + 1);

  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [UW-1:0] head;
  logic          sel_ready;
  logic          push;
  logic          pop;

  always_comb begin
    sel_ready  = 1'b0;
    unit_valid = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (unit_sel == UW'(i)) begin
        sel_ready     = unit_ready[i];
        unit_valid[i] = valid_in && !full && !flush;
      end
    end
  end

  assign ready_out = !full && !flush && sel_ready;
  assign push      = valid_in && ready_out;

  always_comb begin
    valid_out = 1'b0;
    y         = '0;
    fflags    = '0;
    res_ready = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (!empty && (head == UW'(i))) begin
        valid_out    = res_valid[i] && !flush;
        y            = res_data[i*W +: W];
        fflags       = res_flags[i*FFLAG_W +: FFLAG_W];
        res_ready[i] = ready_in && !flush;
      end
    end
  end

  assign pop  = valid_out && ready_in;
  assign busy = (count != '0);

  fpu_order_fifo #(
    .DEPTH (DEPTH),
    .UW    (UW)
  ) u_order_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (unit_sel),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );

endmodule

// File: doc/fpu_dispatcher.md
FPU_DISPATCHER -- requirements
Module: fpu_dispatcher

Interface
REQ-001 The block SHALL have parameter NUM_UNITS, default 7, number of attached FPU functional units.
REQ-002 The block SHALL have parameter DEPTH, default 4, in-flight operation limit (power of two, >=2).
REQ-003 The block SHALL have parameter W, default 32, result width.
REQ-004 The block SHALL have ports, with UW = $clog2(NUM_UNITS):
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous discard of all in-flight operations
valid_in  in  1  upstream operation valid
ready_out  out  1  operation accepted when valid_in high
unit_sel  in  UW  target unit index of the offered operation
unit_valid  out  NUM_UNITS  per-unit valid_in
unit_ready  in  NUM_UNITS  per-unit ready_out
res_valid  in  NUM_UNITS  per-unit result valid
res_ready  out  NUM_UNITS  per-unit result ready
res_data  in  NUM_UNITS*W  per-unit results, unit i in slice i
res_flags  in  NUM_UNITS*5  per-unit {IV,DZ,OF,UF,IE}
valid_out  out  1  retired result valid
ready_in  in  1  downstream ready
y  out  W  retired result
fflags  out  5  retired {IV,DZ,OF,UF,IE}
busy  out  1  at least one operation in flight

Function
REQ-005 The block SHALL drive unit_valid[i] = valid_in && !full && !flush && (unit_sel==i), independent of unit_ready.
REQ-006 The block SHALL drive ready_out = !full && !flush && unit_ready[unit_sel].
REQ-007 On issue (valid_in && ready_out) the block SHALL push unit_sel into a DEPTH-entry order FIFO at the next rising edge.
REQ-008 When FIFO non-empty with head index h, the block SHALL drive valid_out=res_valid[h], y=res_data[h], fflags=res_flags[h], res_ready[h]=ready_in, all other res_ready low.
REQ-009 When FIFO empty, the block SHALL drive valid_out=0, y=0, fflags=0, res_ready=0.
REQ-010 Retirement (valid_out && ready_in) SHALL pop the FIFO head at the next edge; results SHALL retire strictly in issue order.
REQ-011 A result from a non-head unit SHALL be stalled (res_ready low) until that unit reaches the head.
REQ-012 Full (count==DEPTH) SHALL block issue even if a pop occurs the same cycle (no bypass); ready_out rises the cycle after the pop.
REQ-013 Simultaneous push and pop when not full SHALL leave count unchanged and advance both pointers.
REQ-014 A newly issued operation SHALL NOT retire in its issue cycle (no empty-FIFO bypass).
REQ-015 Pointers SHALL wrap modulo DEPTH; count SHALL be $clog2(DEPTH+1) bits, range 0..DEPTH.
REQ-016 flush SHALL force valid_out=0 and res_ready=0 combinationally and clear pointers and count at the next edge, overriding any push or pop that cycle.
REQ-017 busy SHALL equal (count != 0).

Reset
REQ-018 While reset is low, pointers and count SHALL be 0 asynchronously; valid_out, res_ready, y, fflags, busy SHALL be 0 without a clock edge.
REQ-019 Reset mid-operation SHALL discard all in-flight entries; no result SHALL retire after reset release until newly issued.

Structure
REQ-020 Package fpu_pkg SHALL hold unit index constants (FPU_UNIT_ARITH=0, SGN_MOD=1, FTOI=2, ITOF=3, CMP=4, SEL=5, CLASS=6), NUM_FPU_UNITS=7, the fflags bit positions, and the op-to-unit decode function used by the parent.
REQ-021 The order FIFO SHALL be a sub-module fpu_order_fifo (parameters DEPTH, data width UW; push/pop/flush, full/empty/count, head data).

Verification
REQ-022 Issue unit_sel=2, unit 2 returns 0x3F800000 with flags 00001 three cycles later -> valid_out=1, y=0x3F800000, fflags=00001, FIFO empty after handshake.
REQ-023 Issue unit 0 (5-cycle latency) then unit 4 (1-cycle) -> res_ready[4]=0 until unit 0 retires; outputs in order unit 0 then unit 4.
REQ-024 DEPTH=4, four issues without retire -> ready_out=0 on fifth offer; pop with ready_in=1 -> ready_out still 0 that cycle, 1 next.
REQ-025 unit_ready[3]=0 with valid_in=1, unit_sel=3 -> unit_valid[3]=1, ready_out=0, count unchanged.
REQ-026 Flush with count=3 and pending res_valid -> valid_out=0 that cycle, count=0 and busy=0 next cycle, no stale retirement.
REQ-027 Assert reset low asynchronously with count=2 -> valid_out, busy, y drop to 0 before next clk edge.
